uart_rx_fifo: RTL and testbench

Byte buffer between the UART receiver and the host-side consumer. Accepts one byte per `wr_en` pulse from the receiver's FIFO write port and presents bytes in arrival order on a read port. Reports full, almost-full, occupancy and sticky overflow/underflow status for debug and flow control. Single clock domain: write and read both run on `clk`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_if.sv | 34 +++
 rtl/uart_fifo_mem.sv | 38 +++
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and default sizing constants, imported by the RX FIFO
// and reusable by a future TX FIFO.
//   uart_byte_t          : one UART data byte
//   UART_FIFO_DEPTH_DEF  : default FIFO depth (entries)
//   UART_FIFO_AFULL_DEF  : default almost-full threshold (entries)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int UART_FIFO_DEPTH_DEF = 16;
    localparam int UART_FIFO_AFULL_DEF = 12;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Write/read handshake bundle between the UART receiver, the RX FIFO and
// the host-side consumer.
//   wr_data, wr_en : byte and strobe from the receiver
//   full, afull    : flow-control status back to the receiver
//   rd_en          : consumer read request
//   rd_data, empty : head byte and empty status to the consumer
// Modports:
//   master : the receiver/consumer side (drives strobes, sees status)
//   slave  : the FIFO side
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if;
    import uart_pkg::*;

    uart_byte_t wr_data;
    logic       wr_en;
    logic       full;
    logic       afull;
    logic       rd_en;
    uart_byte_t rd_data;
    logic       empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  full, afull, rd_data, empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output full, afull, rd_data, empty
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// Simple dual-port byte array: one synchronous write port, one asynchronous
// read port. Holds no pointer or flag logic so it can back either UART FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write byte
//   raddr : read address
//   rdata : byte at raddr (combinational)
// -----------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    uart_byte_t mem [DEPTH];

    // NOTE: the array has no reset; only the pointers and level decide which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Byte buffer between the UART receiver and the host-side consumer. Bytes are
// presented in arrival order; occupancy, almost-full and sticky
// overflow/underflow status are reported for flow control and debug.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_rx_fifo_if.slave (wr_data/wr_en/full/afull,
//                rd_en/rd_data/empty)
//   level      : current occupancy, 0..DEPTH
//   ovf        : sticky, write seen while full
//   udf        : sticky, read seen while empty
//   err_clr    : synchronous clear of ovf and udf (a same-cycle set wins)
//
// Configuration macro UART_RX_FIFO_FWFT_EN:
//   undefined : rd_data is registered and updates on an accepted read
//   defined   : first-word-fall-through, rd_data shows the head byte
//               combinationally (0x00 while empty)
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH    = UART_FIFO_DEPTH_DEF,
    parameter  int AFULL_TH = UART_FIFO_AFULL_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus,
    output logic [LW-1:0] level,
    output logic          ovf,
    output logic          udf,
    input  logic          err_clr
);

    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_TH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          full;
    logic          empty;
    logic          wr_ok;
    logic          rd_ok;
    uart_byte_t    head;

    // Status comes only from the registered level, so a same-cycle read never
    // makes room for a write and a same-cycle write never feeds a read.
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign wr_ok = bus.wr_en && !full;
    assign rd_ok = bus.rd_en && !empty;

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.afull = (level >= AFULL_LVL);

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_nxt = level;
        unique case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            // Set term is OR-ed last so a new event outranks err_clr.
            ovf <= (ovf && !err_clr) || (bus.wr_en && full);
            udf <= (udf && !err_clr) || (bus.rd_en && empty);
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign bus.rd_data = empty ? '0 : head;
`else
    uart_byte_t rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= head;
        end
    end

    assign bus.rd_data = rd_data_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, AFULL_TH=12).
// Expectations follow the standard read timing unless UART_RX_FIFO_FWFT_EN
// is defined, in which case the head byte is checked before each read.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] level;
    logic       ovf;
    logic       udf;
    logic       err_clr;

    int n_checks = 0;
    int n_fails  = 0;

    uart_byte_t exp_rd;
    uart_byte_t q[$];

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .level   (level),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input uart_byte_t b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_check(input string tag, input uart_byte_t exp);
`ifdef UART_RX_FIFO_FWFT_EN
        check(tag, 32'(bus.rd_data), 32'(exp));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
`else
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check(tag, 32'(bus.rd_data), 32'(exp));
        exp_rd = exp;
`endif
    endtask

    // rd_data expected after a read that found the FIFO empty.
    function automatic uart_byte_t idle_rd();
`ifdef UART_RX_FIFO_FWFT_EN
        return 8'h00;
`else
        return exp_rd;
`endif
    endfunction

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        err_clr     = 1'b0;
        exp_rd      = 8'h00;

        // Reset state
        #3;
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_afull", 32'(bus.afull), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_udf", 32'(udf), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Three bytes in, three out
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        check("basic_level3", 32'(level), 3);
        check("basic_not_empty", 32'(bus.empty), 0);
        read_check("basic_rd0", 8'h11);
        check("basic_level2", 32'(level), 2);
        read_check("basic_rd1", 8'h22);
        check("basic_level1", 32'(level), 1);
        read_check("basic_rd2", 8'h33);
        check("basic_level0", 32'(level), 0);
        check("basic_empty", 32'(bus.empty), 1);

        // Fill to DEPTH, watch thresholds, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            do_write(8'(i));
            check("fill_level", 32'(level), 32'(i + 1));
            check("fill_afull", 32'(bus.afull), 32'((i + 1) >= AFULL_TH));
            check("fill_full", 32'(bus.full), 32'((i + 1) == DEPTH));
        end
        check("fill_ovf_clear", 32'(ovf), 0);
        do_write(8'hAA);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_level", 32'(level), 16);
        for (int i = 0; i < DEPTH; i++) begin
            read_check("drain_data", 8'(i));
        end
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_level", 32'(level), 0);

        // Underflow, clear, and set-beats-clear
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("udf_set", 32'(udf), 1);
        check("udf_rd_data_held", 32'(bus.rd_data), 32'(idle_rd()));
        check("udf_level", 32'(level), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("udf_cleared", 32'(udf), 0);
        check("ovf_cleared", 32'(ovf), 0);
        err_clr   = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        err_clr   = 1'b0;
        bus.rd_en = 1'b0;
        check("udf_set_wins", 32'(udf), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("udf_cleared2", 32'(udf), 0);

        // Steady simultaneous write+read at level 5, pointers wrap
        q.delete();
        for (int i = 0; i < 5; i++) begin
            do_write(8'(8'h40 + i));
            q.push_back(8'(8'h40 + i));
        end
        check("stream_start_level", 32'(level), 5);
        for (int c = 0; c < 40; c++) begin
            uart_byte_t e;
            e = q.pop_front();
            q.push_back(8'(8'h80 + c));
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h80 + c);
            bus.rd_en   = 1'b1;
`ifdef UART_RX_FIFO_FWFT_EN
            check("stream_data", 32'(bus.rd_data), 32'(e));
            tick();
`else
            tick();
            check("stream_data", 32'(bus.rd_data), 32'(e));
            exp_rd = e;
`endif
            check("stream_level", 32'(level), 5);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        while (q.size() > 0) begin
            read_check("stream_tail", q.pop_front());
        end
        check("stream_end_empty", 32'(bus.empty), 1);

        // Write into an empty FIFO and read it back
        do_write(8'h5A);
`ifdef UART_RX_FIFO_FWFT_EN
        check("fwft_show", 32'(bus.rd_data), 32'h5A);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("fwft_after_rd", 32'(bus.rd_data), 0);
`else
        check("std_hold_before_rd", 32'(bus.rd_data), 32'(exp_rd));
        read_check("std_rd_5a", 8'h5A);
`endif
        check("single_empty", 32'(bus.empty), 1);

        // Reset mid-write with 8 stored bytes and a pending underflow flag
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("pre_rst_udf", 32'(udf), 1);
        for (int i = 0; i < 8; i++) begin
            do_write(8'(8'hC0 + i));
        end
        check("pre_rst_level", 32'(level), 8);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_empty", 32'(bus.empty), 1);
        check("mid_rst_rd_data", 32'(bus.rd_data), 0);
        check("mid_rst_udf", 32'(udf), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        bus.wr_en = 1'b0;
        exp_rd    = 8'h00;
        tick();
        #2 rst_n = 1'b1;
        tick();
        do_write(8'h3C);
        check("post_rst_level", 32'(level), 1);
        read_check("post_rst_data", 8'h3C);
        check("post_rst_empty", 32'(bus.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_uart_rx_fifo
